// File: rtl/ctrl_prog_seq_if.sv
// Fetch-sequencer bus: EX-stage redirect/call/return controls in, fetch PC and RAS status out.
interface ctrl_prog_seq_if #(
  parameter int unsigned PROG_CTR_WID = 10,
  parameter int unsigned RAS_DEPTH    = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic                    stall_IF;
  logic                    branch_taken_EX;
  logic                    call_EX;
  logic                    ret_EX;
  logic [PROG_CTR_WID-1:0] nxt_prog_ctr_EX;
  logic [PROG_CTR_WID-1:0] link_addr_EX;
  logic [PROG_CTR_WID-1:0] prog_ctr;
  logic [CNT_W-1:0]        ras_cnt;
  logic                    ras_empty;
  logic                    ras_full;
  logic                    ras_ovf;
  logic                    ras_unf;

  modport master (
    output stall_IF, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
    input  prog_ctr, ras_cnt, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall_IF, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
    output prog_ctr, ras_cnt, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/ctrl_prog_seq.sv
// Program sequencer: registered fetch PC with stall, EX redirect and a circular return-address stack.
module ctrl_prog_seq #(
  parameter int unsigned PROG_CTR_WID = 10,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned RESET_VEC    = 0
) (
  input logic            clk,
  input logic            reset,
  ctrl_prog_seq_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PROG_CTR_WID-1:0] RST_PC  = PROG_CTR_WID'(RESET_VEC);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_INC,
    OP_STALL,
    OP_BRANCH,
    OP_CALL,
    OP_RET
  } op_e;

  op_e                     op;
  logic [PTR_W-1:0]        top;
  logic [PTR_W-1:0]        top_nxt;
  logic [PROG_CTR_WID-1:0] stack [RAS_DEPTH];

  // EX redirects outrank the fetch stall so a flush is never lost.
  always_comb begin
    op = OP_INC;
    if (bus.ret_EX)               op = OP_RET;
    else if (bus.call_EX)         op = OP_CALL;
    else if (bus.branch_taken_EX) op = OP_BRANCH;
    else if (bus.stall_IF)        op = OP_STALL;
  end

  assign top_nxt = top + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.prog_ctr <= RST_PC;
      bus.ras_cnt  <= '0;
      bus.ras_ovf  <= 1'b0;
      bus.ras_unf  <= 1'b0;
      top          <= '0;
    end else begin
      unique case (op)
        OP_RET: begin
          if (bus.ras_cnt != '0) begin
            bus.prog_ctr <= stack[top];
            top          <= top - PTR_W'(1);
            bus.ras_cnt  <= bus.ras_cnt - CNT_W'(1);
          end else begin
            bus.prog_ctr <= RST_PC;
            bus.ras_unf  <= 1'b1;
          end
        end
        OP_CALL: begin
          bus.prog_ctr <= bus.nxt_prog_ctr_EX;
          top          <= top_nxt;
          // When full, the pointer wrap overwrites the oldest entry.
          if (bus.ras_cnt == CNT_MAX) bus.ras_ovf <= 1'b1;
          else                        bus.ras_cnt <= bus.ras_cnt + CNT_W'(1);
        end
        OP_BRANCH: bus.prog_ctr <= bus.nxt_prog_ctr_EX;
        OP_STALL:  bus.prog_ctr <= bus.prog_ctr;
        default:   bus.prog_ctr <= bus.prog_ctr + PROG_CTR_WID'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && op == OP_CALL) stack[top_nxt] <= bus.link_addr_EX;
  end

  assign bus.ras_empty = (bus.ras_cnt == '0);
  assign bus.ras_full  = (bus.ras_cnt == CNT_MAX);

endmodule
